axi_line_bridge: RTL and testbench

- Parametrised successor of the cache-to-AXI bridge.
- Arbitrates N_RD cache read requesters round-robin onto one AXI read channel, and serves one write-back requester on the AW/W/B channels.
- Lines are assembled by indexed beat placement. Requests are latched at accept, AXI response errors are reported, and a read never overtakes an in-flight write to the same line.
- Sits between the I/D caches (and uncached path) and the SoC AXI interconnect.

---
 rtl/axi_line_bridge_pkg.sv | 21 ++
 rtl/axi_line_bridge_if.sv | 63 ++++++
 rtl/axi_line_bridge_rr_arbiter.sv | 45 ++++
 rtl/axi_line_bridge.sv | 197 +++++++++++++++++++
 tb/tb_axi_line_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_line_bridge_pkg.sv
// Shared constants, FSM state types and address helpers for the cache-line AXI bridge.
package axi_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  // Cache line index of a byte address; off_bits = log2(bytes per line).
  function automatic logic [31:0] line_idx(input logic [31:0] addr, input int unsigned off_bits);
    return addr >> off_bits;
  endfunction

  // Bursts longer than one line are trimmed to the line size.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/axi_line_bridge_if.sv
// AXI4 read/write channel bundle between the line bridge and the interconnect.
// master: bridge side (drives AR/AW/W, r_ready, b_ready); slave: interconnect side.
interface axi_line_bridge_if #(
  parameter int unsigned ID_W = 4
);
  logic [ID_W-1:0] ar_id;
  logic [31:0]     ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic            ar_valid;
  logic            ar_ready;

  logic [ID_W-1:0] r_id;
  logic [31:0]     r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            r_valid;
  logic            r_ready;

  logic [31:0]     aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic            aw_valid;
  logic            aw_ready;

  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;
  logic            w_valid;
  logic            w_ready;

  logic [1:0]      b_resp;
  logic            b_valid;
  logic            b_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready,
    output aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready,
    input  aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/axi_line_bridge_rr_arbiter.sv
// Round-robin arbiter.
// Ports: req (N requests), take (current grant is consumed this cycle),
//        any / gnt_idx / gnt (one-hot) describe the combinational winner.
// The pointer holds the first index to consider; it moves past the winner on take.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N-1:0]                        req,
  input  logic                                take,
  output logic                                any,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
  output logic [N-1:0]                        gnt
);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    any     = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      gnt[k] = any && (32'(gnt_idx) == k);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/axi_line_bridge.sv
// Cache-line AXI bridge: N_RD read requesters share one AR/R channel
// (round-robin), one write-back requester uses AW/W/B.
// Ports: aclk/aresetn; rd_* cache read side (valid/addr/len in, ready/done
// pulses, shared assembled line rd_data, rd_err); wr_* write-back side;
// axi: AXI master channels.
module axi_line_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned N_RD       = 2,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned ID_W       = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_RD-1:0]         rd_valid,
  input  logic [32*N_RD-1:0]      rd_addr,
  input  logic [8*N_RD-1:0]       rd_len,
  output logic [N_RD-1:0]         rd_ready,
  output logic [N_RD-1:0]         rd_done,
  output logic [32*LINE_WORDS-1:0] rd_data,
  output logic                    rd_err,
  input  logic                    wr_valid,
  input  logic [31:0]             wr_addr,
  input  logic [7:0]              wr_len,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  input  logic [4*LINE_WORDS-1:0] wr_strb,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    wr_err,
  axi_line_bridge_if.master       axi
);
  localparam int unsigned IDX_W    = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int unsigned BEAT_W   = $clog2(LINE_WORDS);
  localparam int unsigned OFF_BITS = $clog2(4 * LINE_WORDS);
  localparam logic [7:0]  MAX_LEN  = 8'(LINE_WORDS - 1);

  rd_state_e r_state_q, r_state_d;
  wr_state_e w_state_q, w_state_d;

  // ---------------- read path ----------------
  logic [N_RD-1:0]  hazard, eligible, gnt;
  logic [IDX_W-1:0] gnt_idx, r_gnt_q;
  logic             any, take;
  logic [31:0]      sel_addr, r_addr_q;
  logic [7:0]       sel_len, r_len_q;
  logic [BEAT_W-1:0] r_beat_q;
  logic             r_err_q;
  logic [32*LINE_WORDS-1:0] line_q;

  logic [31:0]      w_addr_q;

  // Hazard looks at the registered write state, so a write accepted in the
  // same cycle as a read grant does not block that grant.
  always_comb begin
    hazard   = '0;
    eligible = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      hazard[i]   = (w_state_q != W_IDLE) &&
                    (line_idx(rd_addr[32*i +: 32], OFF_BITS) == line_idx(w_addr_q, OFF_BITS));
      eligible[i] = rd_valid[i] && !hazard[i];
    end
  end

  rr_arbiter #(.N(N_RD)) u_rr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (eligible),
    .take    (take),
    .any     (any),
    .gnt_idx (gnt_idx),
    .gnt     (gnt)
  );

  assign take     = (r_state_q == R_IDLE) && any;
  assign rd_ready = take ? gnt : '0;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      if (32'(gnt_idx) == i) begin
        sel_addr = rd_addr[32*i +: 32];
        sel_len  = rd_len[8*i +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (any)                         r_state_d = R_ADDR;
      R_ADDR:  if (axi.ar_ready)                r_state_d = R_DATA;
      R_DATA:  if (axi.r_valid && axi.r_last)   r_state_d = R_RESP;
      R_RESP:                                   r_state_d = R_IDLE;
      default:                                  r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_err_q   <= 1'b0;
      line_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (take) begin
        r_gnt_q  <= gnt_idx;
        r_addr_q <= sel_addr;
        r_len_q  <= clamp_len(sel_len, MAX_LEN);
        r_beat_q <= '0;
        r_err_q  <= 1'b0;
        line_q   <= '0;
      end else if (r_state_q == R_DATA && axi.r_valid) begin
        line_q[32*r_beat_q +: 32] <= axi.r_data;
        r_beat_q <= r_beat_q + 1'b1;
        r_err_q  <= r_err_q | (axi.r_resp != AXI_RESP_OKAY);
      end
    end
  end

  assign axi.ar_valid = (r_state_q == R_ADDR);
  assign axi.ar_id    = ID_W'(r_gnt_q);
  assign axi.ar_addr  = r_addr_q;
  assign axi.ar_len   = r_len_q;
  assign axi.ar_size  = AXI_SIZE_WORD;
  assign axi.ar_burst = AXI_BURST_INCR;
  assign axi.r_ready  = (r_state_q == R_DATA);

  always_comb begin
    rd_done = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      rd_done[i] = (r_state_q == R_RESP) && (32'(r_gnt_q) == i);
    end
  end
  assign rd_err  = (r_state_q == R_RESP) && r_err_q;
  assign rd_data = line_q;

  // ---------------- write path ----------------
  logic [7:0]               w_len_q;
  logic [32*LINE_WORDS-1:0] w_line_q;
  logic [4*LINE_WORDS-1:0]  w_strb_q;
  logic [BEAT_W-1:0]        w_beat_q;
  logic                     w_last_beat;

  assign w_last_beat = (8'(w_beat_q) == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_valid)                       w_state_d = W_ADDR;
      W_ADDR:  if (axi.aw_ready)                   w_state_d = W_DATA;
      W_DATA:  if (axi.w_ready && w_last_beat)     w_state_d = W_RESP;
      W_RESP:  if (axi.b_valid)                    w_state_d = W_IDLE;
      default:                                     w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_line_q  <= '0;
      w_strb_q  <= '0;
      w_beat_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (w_state_q == W_IDLE && wr_valid) begin
        w_addr_q <= wr_addr;
        w_len_q  <= clamp_len(wr_len, MAX_LEN);
        w_line_q <= wr_data;
        w_strb_q <= wr_strb;
        w_beat_q <= '0;
      end else if (w_state_q == W_DATA && axi.w_ready) begin
        w_beat_q <= w_beat_q + 1'b1;
      end
    end
  end

  assign wr_ready     = (w_state_q == W_IDLE) && wr_valid;
  assign axi.aw_valid = (w_state_q == W_ADDR);
  assign axi.aw_addr  = w_addr_q;
  assign axi.aw_len   = w_len_q;
  assign axi.aw_size  = AXI_SIZE_WORD;
  assign axi.aw_burst = AXI_BURST_INCR;
  assign axi.w_valid  = (w_state_q == W_DATA);
  assign axi.w_data   = w_line_q[32*w_beat_q +: 32];
  assign axi.w_strb   = w_strb_q[4*w_beat_q +: 4];
  assign axi.w_last   = (w_state_q == W_DATA) && w_last_beat;
  assign axi.b_ready  = (w_state_q == W_RESP);
  assign wr_done      = (w_state_q == W_RESP) && axi.b_valid;
  assign wr_err       = wr_done && (axi.b_resp != AXI_RESP_OKAY);
endmodule

// File: tb/tb_axi_line_bridge.sv
// Directed self-checking bench for axi_line_bridge (N_RD=2, LINE_WORDS=16).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_axi_line_bridge;
  logic          aclk = 1'b0;
  logic          aresetn;
  logic [1:0]    rd_valid;
  logic [63:0]   rd_addr;
  logic [15:0]   rd_len;
  logic [1:0]    rd_ready, rd_done;
  logic [511:0]  rd_data;
  logic          rd_err;
  logic          wr_valid;
  logic [31:0]   wr_addr;
  logic [7:0]    wr_len;
  logic [511:0]  wr_data;
  logic [63:0]   wr_strb;
  logic          wr_ready, wr_done, wr_err;

  int checks = 0;
  int errors = 0;

  axi_line_bridge_if #(.ID_W(4)) axi_bus ();

  axi_line_bridge #(.N_RD(2), .LINE_WORDS(16), .ID_W(4)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_ready (rd_ready),
    .rd_done  (rd_done),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_len   (wr_len),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .wr_ready (wr_ready),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .axi      (axi_bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is in R_ADDR; completes the AR handshake and lands in R_DATA.
  task automatic ar_hs();
    axi_bus.ar_ready = 1'b1;
    @(negedge aclk);
    axi_bus.ar_ready = 1'b0;
    #1;
  endtask

  // Sends n back-to-back R beats (data = base+k); ends in R_RESP, sampled.
  task automatic send_beats(input int n, input logic [31:0] base, input logic [1:0] resp);
    for (int k = 0; k < n; k++) begin
      axi_bus.r_valid = 1'b1;
      axi_bus.r_data  = base + 32'(k);
      axi_bus.r_resp  = resp;
      axi_bus.r_last  = (k == n - 1);
      @(negedge aclk);
    end
    axi_bus.r_valid = 1'b0;
    axi_bus.r_last  = 1'b0;
    axi_bus.r_resp  = 2'b00;
    #1;
  endtask

  initial begin
    int b;
    logic tog;
    logic [3:0] exp_strb;

    aresetn = 1'b0;
    rd_valid = '0; rd_addr = '0; rd_len = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_strb = '0;
    axi_bus.ar_ready = 1'b0; axi_bus.r_id = '0; axi_bus.r_data = '0; axi_bus.r_resp = '0;
    axi_bus.r_last = 1'b0; axi_bus.r_valid = 1'b0; axi_bus.aw_ready = 1'b0;
    axi_bus.w_ready = 1'b0; axi_bus.b_resp = '0; axi_bus.b_valid = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_ar_valid", 64'(axi_bus.ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(axi_bus.aw_valid), 64'd0);
    chk("rst_w_valid", 64'(axi_bus.w_valid), 64'd0);
    chk("rst_r_ready", 64'(axi_bus.r_ready), 64'd0);
    chk("rst_b_ready", 64'(axi_bus.b_ready), 64'd0);
    chk("rst_rd_data_zero", 64'(rd_data == '0), 64'd1);
    @(negedge aclk);
    aresetn = 1'b1;

    // ---- both requesters held: grants 0,1,0 ----
    @(negedge aclk);
    rd_valid = 2'b11;
    rd_addr  = {32'h0000_0200, 32'h0000_0100};
    rd_len   = 16'h0000;
    #1;
    chk("rr1_rd_ready", 64'(rd_ready), 64'h1);
    @(negedge aclk); #1;
    chk("rr1_ar_id", 64'(axi_bus.ar_id), 64'd0);
    chk("rr1_ar_addr", 64'(axi_bus.ar_addr), 64'h100);
    ar_hs();
    send_beats(1, 32'h11, 2'b00);
    chk("rr1_rd_done", 64'(rd_done), 64'h1);
    chk("rr1_word0", 64'(rd_data[31:0]), 64'h11);
    @(negedge aclk); #1;
    chk("rr2_rd_ready", 64'(rd_ready), 64'h2);
    @(negedge aclk); #1;
    chk("rr2_ar_id", 64'(axi_bus.ar_id), 64'd1);
    chk("rr2_ar_addr", 64'(axi_bus.ar_addr), 64'h200);
    ar_hs();
    send_beats(1, 32'h22, 2'b00);
    chk("rr2_rd_done", 64'(rd_done), 64'h2);
    @(negedge aclk); #1;
    chk("rr3_rd_ready", 64'(rd_ready), 64'h1);
    @(negedge aclk); #1;
    chk("rr3_ar_id", 64'(axi_bus.ar_id), 64'd0);
    ar_hs();
    send_beats(1, 32'h33, 2'b00);
    chk("rr3_rd_done", 64'(rd_done), 64'h1);
    rd_valid = 2'b00;

    // ---- single I-fetch, 16 beats ----
    @(negedge aclk);
    rd_valid = 2'b01;
    rd_addr[31:0] = 32'h1C00_0000;
    rd_len[7:0]   = 8'd15;
    #1;
    chk("if_rd_ready", 64'(rd_ready), 64'h1);
    @(negedge aclk);
    rd_valid = 2'b00;
    #1;
    chk("if_ar_valid", 64'(axi_bus.ar_valid), 64'd1);
    chk("if_ar_addr", 64'(axi_bus.ar_addr), 64'h1C00_0000);
    chk("if_ar_len", 64'(axi_bus.ar_len), 64'd15);
    chk("if_ar_size", 64'(axi_bus.ar_size), 64'd2);
    chk("if_ar_burst", 64'(axi_bus.ar_burst), 64'd1);
    ar_hs();
    chk("if_r_ready", 64'(axi_bus.r_ready), 64'd1);
    send_beats(16, 32'd0, 2'b00);
    chk("if_rd_done", 64'(rd_done), 64'h1);
    chk("if_rd_err", 64'(rd_err), 64'd0);
    chk("if_word0", 64'(rd_data[31:0]), 64'd0);
    chk("if_word1", 64'(rd_data[63:32]), 64'd1);
    chk("if_word7", 64'(rd_data[255:224]), 64'd7);
    chk("if_word15", 64'(rd_data[511:480]), 64'd15);
    @(negedge aclk); #1;
    chk("if_rd_done_pulse", 64'(rd_done), 64'd0);

    // ---- uncached single-beat read with SLVERR ----
    rd_valid = 2'b10;
    rd_addr[63:32] = 32'h1FE0_01E0;
    rd_len[15:8]   = 8'd0;
    #1;
    chk("uc_rd_ready", 64'(rd_ready), 64'h2);
    @(negedge aclk);
    rd_valid = 2'b00;
    #1;
    chk("uc_ar_addr", 64'(axi_bus.ar_addr), 64'h1FE0_01E0);
    chk("uc_ar_len", 64'(axi_bus.ar_len), 64'd0);
    chk("uc_ar_id", 64'(axi_bus.ar_id), 64'd1);
    ar_hs();
    send_beats(1, 32'hDEAD_BEEF, 2'b10);
    chk("uc_rd_done", 64'(rd_done), 64'h2);
    chk("uc_rd_err", 64'(rd_err), 64'd1);
    chk("uc_word0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    chk("uc_word1", 64'(rd_data[63:32]), 64'd0);
    chk("uc_word15", 64'(rd_data[511:480]), 64'd0);

    // ---- write-back with toggling w_ready ----
    for (int k = 0; k < 16; k++) begin
      wr_data[32*k +: 32] = 32'hA000_0000 + 32'(k);
      wr_strb[4*k +: 4]   = 4'hF;
    end
    wr_strb[15:12] = 4'b0011;
    @(negedge aclk);
    wr_valid = 1'b1;
    wr_addr  = 32'h0000_3000;
    wr_len   = 8'd15;
    #1;
    chk("wb_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge aclk);
    wr_valid = 1'b0;
    #1;
    chk("wb_aw_valid", 64'(axi_bus.aw_valid), 64'd1);
    chk("wb_aw_addr", 64'(axi_bus.aw_addr), 64'h3000);
    chk("wb_aw_len", 64'(axi_bus.aw_len), 64'd15);
    chk("wb_aw_size", 64'(axi_bus.aw_size), 64'd2);
    chk("wb_aw_burst", 64'(axi_bus.aw_burst), 64'd1);
    axi_bus.aw_ready = 1'b1;
    @(negedge aclk);
    axi_bus.aw_ready = 1'b0;
    b = 0;
    tog = 1'b0;
    for (int c = 0; c < 40 && b < 16; c++) begin
      axi_bus.w_ready = tog;
      #1;
      exp_strb = (b == 3) ? 4'b0011 : 4'hF;
      chk("wb_w_valid", 64'(axi_bus.w_valid), 64'd1);
      chk("wb_w_data", 64'(axi_bus.w_data), 64'(32'hA000_0000 + 32'(b)));
      chk("wb_w_strb", 64'(axi_bus.w_strb), 64'(exp_strb));
      chk("wb_w_last", 64'(axi_bus.w_last), 64'(b == 15));
      if (tog) b++;
      tog = ~tog;
      @(negedge aclk);
    end
    axi_bus.w_ready = 1'b0;
    #1;
    chk("wb_beat_count", 64'(b), 64'd16);
    chk("wb_w_valid_end", 64'(axi_bus.w_valid), 64'd0);
    chk("wb_b_ready", 64'(axi_bus.b_ready), 64'd1);
    chk("wb_wr_done_early", 64'(wr_done), 64'd0);
    axi_bus.b_valid = 1'b1;
    axi_bus.b_resp  = 2'b00;
    #1;
    chk("wb_wr_done", 64'(wr_done), 64'd1);
    chk("wb_wr_err", 64'(wr_err), 64'd0);
    @(negedge aclk);
    axi_bus.b_valid = 1'b0;
    #1;
    chk("wb_wr_done_pulse", 64'(wr_done), 64'd0);
    chk("wb_b_ready_idle", 64'(axi_bus.b_ready), 64'd0);

    // ---- same-line hazard, oversize write length clamps ----
    @(negedge aclk);
    wr_valid = 1'b1;
    wr_addr  = 32'h0000_1000;
    wr_len   = 8'd255;
    #1;
    chk("hz_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge aclk);
    wr_valid = 1'b0;
    rd_valid = 2'b10;
    rd_addr[63:32] = 32'h0000_1004;
    rd_len[15:8]   = 8'd0;
    #1;
    chk("hz_aw_len_clamp", 64'(axi_bus.aw_len), 64'd15);
    chk("hz_blocked0", 64'(rd_ready), 64'd0);
    repeat (3) @(negedge aclk);
    #1;
    chk("hz_blocked1", 64'(rd_ready), 64'd0);
    chk("hz_no_ar", 64'(axi_bus.ar_valid), 64'd0);
    rd_valid = 2'b11;
    rd_addr[31:0] = 32'h0000_2000;
    rd_len[7:0]   = 8'd0;
    #1;
    chk("hz_other_granted", 64'(rd_ready), 64'h1);
    @(negedge aclk);
    rd_valid = 2'b10;
    #1;
    chk("hz_other_ar_addr", 64'(axi_bus.ar_addr), 64'h2000);
    ar_hs();
    send_beats(1, 32'h77, 2'b00);
    chk("hz_other_done", 64'(rd_done), 64'h1);
    @(negedge aclk); #1;
    chk("hz_blocked2", 64'(rd_ready), 64'd0);
    axi_bus.aw_ready = 1'b1;
    @(negedge aclk);
    axi_bus.aw_ready = 1'b0;
    axi_bus.w_ready  = 1'b1;
    repeat (16) @(negedge aclk);
    axi_bus.w_ready = 1'b0;
    axi_bus.b_valid = 1'b1;
    axi_bus.b_resp  = 2'b00;
    #1;
    chk("hz_wr_done", 64'(wr_done), 64'd1);
    chk("hz_blocked3", 64'(rd_ready), 64'd0);
    @(negedge aclk);
    axi_bus.b_valid = 1'b0;
    #1;
    chk("hz_released", 64'(rd_ready), 64'h2);
    @(negedge aclk);
    rd_valid = 2'b00;
    #1;
    chk("hz_rd_ar_addr", 64'(axi_bus.ar_addr), 64'h1004);
    chk("hz_rd_ar_id", 64'(axi_bus.ar_id), 64'd1);
    ar_hs();
    send_beats(1, 32'h88, 2'b00);
    chk("hz_rd_done", 64'(rd_done), 64'h2);

    // ---- reset during beat 5 of a burst ----
    @(negedge aclk);
    rd_valid = 2'b01;
    rd_addr[31:0] = 32'h1C00_0040;
    rd_len[7:0]   = 8'd15;
    #1;
    chk("rs_rd_ready", 64'(rd_ready), 64'h1);
    @(negedge aclk);
    rd_valid = 2'b00;
    #1;
    ar_hs();
    for (int k = 0; k < 5; k++) begin
      axi_bus.r_valid = 1'b1;
      axi_bus.r_data  = 32'h100 + 32'(k);
      @(negedge aclk);
    end
    axi_bus.r_data = 32'h105;
    aresetn = 1'b0;
    #1;
    chk("rs_r_ready", 64'(axi_bus.r_ready), 64'd0);
    chk("rs_rd_done", 64'(rd_done), 64'd0);
    chk("rs_ar_valid", 64'(axi_bus.ar_valid), 64'd0);
    chk("rs_rd_data_zero", 64'(rd_data == '0), 64'd1);
    axi_bus.r_valid = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    chk("rs_rd_done_held", 64'(rd_done), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    rd_valid = 2'b01;
    rd_addr[31:0] = 32'h0000_0040;
    rd_len[7:0]   = 8'd3;
    #1;
    chk("rs2_rd_ready", 64'(rd_ready), 64'h1);
    @(negedge aclk);
    rd_valid = 2'b00;
    #1;
    chk("rs2_ar_len", 64'(axi_bus.ar_len), 64'd3);
    ar_hs();
    send_beats(4, 32'h50, 2'b00);
    chk("rs2_rd_done", 64'(rd_done), 64'h1);
    chk("rs2_rd_err", 64'(rd_err), 64'd0);
    chk("rs2_word3", 64'(rd_data[127:96]), 64'h53);
    chk("rs2_word4", 64'(rd_data[159:128]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
